dmem_read_slave: RTL and testbench

- Data-memory read-side slave. Sits directly downstream of the load unit on the data memory bus.
- Accepts read addresses on the AR channel, issues word reads to a synchronous single-cycle SRAM, and returns byte-aligned data on the R channel.
- Holds up to two outstanding reads in order. Handles R-channel backpressure without dropping or reordering responses.

---
 rtl/dmem_read_slave.sv | 131 +++++++++++++
 tb/tb_dmem_read_slave.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_read_slave.sv
// Data-memory read slave: AR channel in, single-cycle SRAM reads, byte-aligned R responses.
// Up to two reads outstanding, returned in order through a 2-entry response FIFO.
module dmem_read_slave #(
  parameter  int XLEN        = 32,
  parameter  int DEPTH_WORDS = 1024,
  localparam int MEM_AW      = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_arvalid,
  output logic              o_arready,
  input  logic [XLEN-1:0]   i_araddr,
  output logic              o_rvalid,
  input  logic              i_rready,
  output logic [XLEN-1:0]   o_rdata,
  output logic              o_rerr,
  output logic              o_mem_en,
  output logic [MEM_AW-1:0] o_mem_addr,
  input  logic [XLEN-1:0]   i_mem_rdata
);

  logic [1:0]      cnt;
  logic            ar_hs;
  logic            r_hs;
  logic            in_range;

  logic            if_v;
  logic            if_err;
  logic [1:0]      if_off;

  logic            push;
  logic            push_err;
  logic [XLEN-1:0] push_data;

  // Head (slot 0) drives the R channel; slot 1 queues behind it.
  logic            h_v;
  logic            h_err;
  logic [XLEN-1:0] h_data;
  logic            s_v;
  logic            s_err;
  logic [XLEN-1:0] s_data;
  logic            s_load;

  assign o_rvalid = h_v;
  assign o_rdata  = h_data;
  assign o_rerr   = h_err;

  // A pop in this cycle frees a credit, so a new read may be accepted even at cnt==2.
  assign r_hs      = h_v & i_rready;
  assign o_arready = rstn & ((cnt < 2'd2) | r_hs);
  assign ar_hs     = i_arvalid & o_arready;

  assign in_range   = (i_araddr >> (MEM_AW + 2)) == '0;
  assign o_mem_en   = ar_hs & in_range;
  assign o_mem_addr = i_araddr[MEM_AW+1:2];

  assign push      = if_v;
  assign push_err  = if_err;
  assign push_data = if_err ? '0 : (i_mem_rdata >> {if_off, 3'b000});

  // Slot 1 is written when the head stays occupied: push without pop, or push+pop with slot 1 full.
  assign s_load = push & h_v & (~r_hs | s_v);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt    <= 2'd0;
      if_v   <= 1'b0;
      if_err <= 1'b0;
      if_off <= 2'd0;
    end else begin
      unique case ({ar_hs, r_hs})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
      if_v   <= ar_hs;
      if_err <= ~in_range;
      if_off <= i_araddr[1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      h_v    <= 1'b0;
      h_err  <= 1'b0;
      h_data <= '0;
      s_v    <= 1'b0;
    end else begin
      unique case ({r_hs, push})
        2'b01: begin
          if (!h_v) begin
            h_v    <= 1'b1;
            h_err  <= push_err;
            h_data <= push_data;
          end else begin
            s_v <= 1'b1;
          end
        end
        2'b10: begin
          if (s_v) begin
            h_err  <= s_err;
            h_data <= s_data;
            s_v    <= 1'b0;
          end else begin
            h_v <= 1'b0;
          end
        end
        2'b11: begin
          if (s_v) begin
            h_err  <= s_err;
            h_data <= s_data;
          end else begin
            h_err  <= push_err;
            h_data <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: slot 1 payload is never observed unless s_v is set, so it carries no reset.
  always_ff @(posedge clk) begin
    if (s_load) begin
      s_err  <= push_err;
      s_data <= push_data;
    end
  end

endmodule

// File: tb/tb_dmem_read_slave.sv
// Directed self-checking bench for dmem_read_slave with a behavioural single-cycle SRAM.
module tb_dmem_read_slave;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        i_arvalid = 1'b0;
  logic        i_rready = 1'b0;
  logic [31:0] i_araddr = '0;
  logic        o_arready;
  logic        o_rvalid;
  logic [31:0] o_rdata;
  logic        o_rerr;
  logic        o_mem_en;
  logic [9:0]  o_mem_addr;
  logic [31:0] mem_rdata;

  logic [31:0] mem [1024];
  int          n_tests = 0;
  int          n_fail = 0;
  int          outst = 0;
  logic        ovf = 1'b0;

  always #5 clk = ~clk;

  dmem_read_slave #(.XLEN(32), .DEPTH_WORDS(1024)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .i_arvalid  (i_arvalid),
    .o_arready  (o_arready),
    .i_araddr   (i_araddr),
    .o_rvalid   (o_rvalid),
    .i_rready   (i_rready),
    .o_rdata    (o_rdata),
    .o_rerr     (o_rerr),
    .o_mem_en   (o_mem_en),
    .o_mem_addr (o_mem_addr),
    .i_mem_rdata(mem_rdata)
  );

  always @(posedge clk) if (o_mem_en) mem_rdata <= mem[o_mem_addr];

  // Outstanding reads seen on the bus must never exceed the two credits.
  always @(negedge clk) begin
    if (!rstn) outst = 0;
    else begin
      outst = outst + int'(i_arvalid & o_arready) - int'(o_rvalid & i_rready);
      if (outst > 2 || outst < 0) ovf = 1'b1;
    end
  end

  function automatic logic [31:0] wval(input int w);
    return 32'hC0DE_0000 ^ (32'(w) * 32'h0001_0101);
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One isolated read with i_rready high: handshake, one quiet cycle, response.
  task automatic do_read(input logic [31:0] addr, input logic [31:0] exp_data, input logic exp_err);
    logic [31:0] a;
    a = addr;
    tick();
    i_arvalid = 1'b1;
    i_araddr  = a;
    #1;
    check("rd_arready", 32'(o_arready), 32'd1);
    check("rd_mem_en", 32'(o_mem_en), 32'(!exp_err));
    if (!exp_err) check("rd_mem_addr", 32'(o_mem_addr), 32'(a[11:2]));
    tick();
    i_arvalid = 1'b0;
    #1;
    check("rd_no_early_rvalid", 32'(o_rvalid), 32'd0);
    tick();
    check("rd_rvalid", 32'(o_rvalid), 32'd1);
    check("rd_rdata", o_rdata, exp_data);
    check("rd_rerr", 32'(o_rerr), 32'(exp_err));
  endtask

  logic [31:0] il_addr [3];
  logic [31:0] il_data [3];
  logic        il_err  [3];

  initial begin
    for (int w = 0; w < 1024; w++) mem[w] = wval(w);
    mem[256] = 32'hDEAD_BEEF;

    // Reset state, with a request pending to show it is ignored
    i_arvalid = 1'b1;
    i_araddr  = 32'h400;
    tick();
    check("rst_rvalid", 32'(o_rvalid), 32'd0);
    check("rst_rdata", o_rdata, 32'd0);
    check("rst_rerr", 32'(o_rerr), 32'd0);
    check("rst_arready", 32'(o_arready), 32'd0);
    check("rst_mem_en", 32'(o_mem_en), 32'd0);
    rstn      = 1'b1;
    i_arvalid = 1'b0;
    i_rready  = 1'b1;

    // Single read and byte offsets
    do_read(32'h400, 32'hDEAD_BEEF, 1'b0);
    do_read(32'h403, 32'h0000_00DE, 1'b0);
    do_read(32'h402, 32'h0000_DEAD, 1'b0);
    do_read(32'h401, 32'h00DE_ADBE, 1'b0);
    do_read(32'h1000, 32'h0, 1'b1);
    do_read(32'hFFC, wval(1023), 1'b0);

    // Streaming: 8 back-to-back reads, responses on cycles 2..9
    for (int c = 0; c < 10; c++) begin
      tick();
      i_arvalid = (c < 8);
      i_araddr  = 32'h404 + 32'(4 * c);
      #1;
      if (c < 8) check("st_arready", 32'(o_arready), 32'd1);
      if (c >= 2) begin
        check("st_rvalid", 32'(o_rvalid), 32'd1);
        check("st_rdata", o_rdata, wval(32'h101 + c - 2));
        check("st_rerr", 32'(o_rerr), 32'd0);
      end
    end
    tick();
    check("st_drained", 32'(o_rvalid), 32'd0);

    // Out-of-range read interleaved between two in-range reads
    il_addr = '{32'h404, 32'h1000, 32'h408};
    il_data = '{wval(32'h101), 32'h0, wval(32'h102)};
    il_err  = '{1'b0, 1'b1, 1'b0};
    for (int c = 0; c < 5; c++) begin
      tick();
      i_arvalid = (c < 3);
      i_araddr  = (c < 3) ? il_addr[c] : 32'h0;
      #1;
      if (c < 3) check("il_mem_en", 32'(o_mem_en), 32'(!il_err[c]));
      if (c >= 2) begin
        check("il_rvalid", 32'(o_rvalid), 32'd1);
        check("il_rdata", o_rdata, il_data[c-2]);
        check("il_rerr", 32'(o_rerr), 32'(il_err[c-2]));
      end
    end
    tick();
    check("il_drained", 32'(o_rvalid), 32'd0);

    // Backpressure: two accepted, then arready low until the first pop
    i_rready = 1'b0;
    tick();
    i_arvalid = 1'b1;
    i_araddr  = 32'h40C;
    #1;
    check("bp_ar0", 32'(o_arready), 32'd1);
    tick();
    i_araddr = 32'h410;
    #1;
    check("bp_ar1", 32'(o_arready), 32'd1);
    tick();
    i_araddr = 32'h414;
    #1;
    check("bp_full_arready", 32'(o_arready), 32'd0);
    check("bp_full_rvalid", 32'(o_rvalid), 32'd1);
    check("bp_full_rdata", o_rdata, wval(32'h103));
    for (int k = 0; k < 2; k++) begin
      tick();
      check("bp_hold_arready", 32'(o_arready), 32'd0);
      check("bp_hold_rvalid", 32'(o_rvalid), 32'd1);
      check("bp_hold_rdata", o_rdata, wval(32'h103));
    end
    tick();
    i_rready = 1'b1;
    #1;
    check("bp_arready_on_pop", 32'(o_arready), 32'd1);
    check("bp_pop0", o_rdata, wval(32'h103));
    tick();
    i_arvalid = 1'b0;
    #1;
    check("bp_pop1_rvalid", 32'(o_rvalid), 32'd1);
    check("bp_pop1", o_rdata, wval(32'h104));
    tick();
    check("bp_pop2_rvalid", 32'(o_rvalid), 32'd1);
    check("bp_pop2", o_rdata, wval(32'h105));
    tick();
    check("bp_drained", 32'(o_rvalid), 32'd0);

    // Reset with two reads outstanding discards them
    i_rready = 1'b0;
    tick();
    i_arvalid = 1'b1;
    i_araddr  = 32'h418;
    #1;
    check("rm_ar0", 32'(o_arready), 32'd1);
    tick();
    i_araddr = 32'h41C;
    #1;
    check("rm_ar1", 32'(o_arready), 32'd1);
    tick();
    i_arvalid = 1'b0;
    rstn      = 1'b0;
    #1;
    check("rm_arready_in_rst", 32'(o_arready), 32'd0);
    check("rm_rvalid_pre_rst", 32'(o_rvalid), 32'd1);
    tick();
    rstn     = 1'b1;
    i_rready = 1'b1;
    #1;
    check("rm_rvalid_cleared", 32'(o_rvalid), 32'd0);
    check("rm_rdata_cleared", o_rdata, 32'd0);
    check("rm_arready", 32'(o_arready), 32'd1);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("rm_no_stale", 32'(o_rvalid), 32'd0);
    end
    do_read(32'h420, wval(32'h108), 1'b0);
    tick();
    check("rm_final_drained", 32'(o_rvalid), 32'd0);

    check("no_credit_overflow", 32'(ovf), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
